// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, state encodings and timing
// helpers for the 4-bit character LCD text controller.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC  = 8'h28;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_DISP  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_DDRAM = 8'h80;
  localparam logic [7:0] ROW1_OFF  = 8'h40;

  typedef enum logic [2:0] {
    POWER_WAIT,
    INIT,
    IDLE,
    SET_ADDR,
    WRITE_CHAR
  } lcd_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SU,
    TX_HI,
    TX_POST
  } tx_state_t;

  // Delays round up so every LCD minimum is honoured.
  function automatic int us_to_cyc(
    input longint hz,
    input longint us
  );
    return int'((us * hz + 999_999) / 1_000_000);
  endfunction

  function automatic int ns_to_cyc(
    input longint hz,
    input longint ns
  );
    return int'((ns * hz + 999_999_999) / 1_000_000_000);
  endfunction

  // Power-on sequence: four lone nibbles, then four
  // command bytes sent high nibble first.
  function automatic logic [3:0] init_nib(
    input logic [3:0] step
  );
    logic [7:0] b;
    case (step[3:1])
      3'd2:    b = CMD_FUNC;
      3'd3:    b = CMD_ENTRY;
      3'd4:    b = CMD_DISP;
      default: b = CMD_CLEAR;
    endcase
    if (step < 4'd3) return 4'h3;
    if (step == 4'd3) return 4'h2;
    return step[0] ? b[3:0] : b[7:4];
  endfunction

endpackage

// File: rtl/lcd_text_ctrl_if.sv
// lcd_text_ctrl_if: host side of the text controller.
// Buffer write port, repaint request and busy status.
interface lcd_text_ctrl_if #(
  parameter int AW = 6
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          refresh_req;
  logic          busy;

  modport master (
    output wr_en, wr_addr, wr_data, refresh_req,
    input  busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, refresh_req,
    output busy
  );
endinterface

// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: one LCD nibble strobe with setup, pulse
// width, hold and a caller-chosen post delay; pulses done.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  nib,
  input  logic        rs,
  input  logic [31:0] post,
  output logic        done,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic [3:0]  lcd_d
);

  localparam logic [31:0] C_SU =
    32'(ns_to_cyc(CLK_HZ, 40) - 1);
  localparam logic [31:0] C_PW =
    32'(ns_to_cyc(CLK_HZ, 230) - 1);

  tx_state_t   st_q, st_n;
  logic [31:0] cnt_q, cnt_n;
  logic [31:0] post_q, post_n;
  logic        e_q, e_n;
  logic        rs_q, rs_n;
  logic [3:0]  d_q, d_n;
  logic        done_q, done_n;

  always_comb begin
    st_n   = st_q;
    cnt_n  = cnt_q;
    post_n = post_q;
    e_n    = e_q;
    rs_n   = rs_q;
    d_n    = d_q;
    done_n = 1'b0;
    unique case (st_q)
      TX_IDLE: if (start) begin
        d_n    = nib;
        rs_n   = rs;
        post_n = post;
        cnt_n  = C_SU;
        st_n   = TX_SU;
      end
      TX_SU: if (cnt_q == '0) begin
        e_n   = 1'b1;
        cnt_n = C_PW;
        st_n  = TX_HI;
      end else begin
        cnt_n = cnt_q - 32'd1;
      end
      TX_HI: if (cnt_q == '0) begin
        // rs/d stay put after the fall: covers hold time
        e_n   = 1'b0;
        cnt_n = (post_q == '0) ? '0 : post_q - 32'd1;
        st_n  = TX_POST;
      end else begin
        cnt_n = cnt_q - 32'd1;
      end
      TX_POST: if (cnt_q == '0) begin
        done_n = 1'b1;
        st_n   = TX_IDLE;
      end else begin
        cnt_n = cnt_q - 32'd1;
      end
      default: st_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= TX_IDLE;
      cnt_q  <= '0;
      post_q <= '0;
      e_q    <= 1'b0;
      rs_q   <= 1'b0;
      d_q    <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_n;
      cnt_q  <= cnt_n;
      post_q <= post_n;
      e_q    <= e_n;
      rs_q   <= rs_n;
      d_q    <= d_n;
      done_q <= done_n;
    end
  end

  assign done   = done_q;
  assign lcd_e  = e_q;
  assign lcd_rs = rs_q;
  assign lcd_d  = d_q;

endmodule

// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl: character buffer plus init/repaint FSM
// for a 4-bit HD44780 LCD; host port via lcd_text_ctrl_if.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int ROWS       = 2,
  parameter int COLS       = 16,
  parameter int REFRESH_HZ = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  lcd_text_ctrl_if.slave   host,
  output logic             sf_e,
  output logic             lcd_e,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic [3:0]       lcd_d
);

  localparam int DEPTH = ROWS * COLS;
  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = $clog2(COLS);
  localparam int TICK  =
    CLK_HZ / ((REFRESH_HZ > 0) ? REFRESH_HZ : 1);

  localparam logic [31:0] P_PWR  =
    32'(us_to_cyc(CLK_HZ, 15000));
  localparam logic [31:0] P_4100 =
    32'(us_to_cyc(CLK_HZ, 4100));
  localparam logic [31:0] P_1640 =
    32'(us_to_cyc(CLK_HZ, 1640));
  localparam logic [31:0] P_100  =
    32'(us_to_cyc(CLK_HZ, 100));
  localparam logic [31:0] P_40   =
    32'(us_to_cyc(CLK_HZ, 40));
  localparam logic [31:0] P_1    =
    32'(us_to_cyc(CLK_HZ, 1));

  lcd_state_t  st_q, st_n;
  logic [31:0] wcnt_q, wcnt_n;
  logic [3:0]  step_q, step_n;
  logic        lo_q, lo_n;
  logic        row_q, row_n;
  logic [CW-1:0] col_q, col_n;
  logic [7:0]  byte_q, byte_n;
  logic        act_q, act_n;
  logic        pend_q, pend_n;
  logic        busy_q;
  logic [31:0] tick_q;

  logic [7:0]  mem [DEPTH];
  logic [IW-1:0] rd_addr;
  logic [7:0]  rd_char;
  logic [7:0]  cmd;
  logic        tick;
  logic        req;

  logic        tx_start;
  logic [3:0]  tx_nib;
  logic        tx_rs;
  logic [31:0] tx_post;
  logic        tx_done;

  assign tick = (REFRESH_HZ > 0) &&
                (tick_q == 32'(TICK - 1));
  assign req  = host.refresh_req | tick;

  assign rd_addr =
    IW'(int'(row_q) * COLS + int'(col_q));
  assign rd_char = mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 8'h20;
    end else if (host.wr_en &&
                 int'(host.wr_addr) < DEPTH) begin
      mem[host.wr_addr[IW-1:0]] <= host.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tick_q <= '0;
    else if (tick_q == 32'(TICK - 1))
      tick_q <= '0;
    else
      tick_q <= tick_q + 32'd1;
  end

  always_comb begin
    st_n     = st_q;
    wcnt_n   = wcnt_q;
    step_n   = step_q;
    lo_n     = lo_q;
    row_n    = row_q;
    col_n    = col_q;
    byte_n   = byte_q;
    act_n    = act_q;
    // requests while busy collapse into one flag
    pend_n   = pend_q | req;
    tx_start = 1'b0;
    tx_nib   = 4'h0;
    tx_rs    = 1'b0;
    tx_post  = P_1;
    cmd      = CMD_DDRAM | (row_q ? ROW1_OFF : 8'h00);
    unique case (st_q)
      POWER_WAIT: begin
        if (wcnt_q == P_PWR - 32'd1) begin
          wcnt_n = '0;
          st_n   = INIT;
        end else begin
          wcnt_n = wcnt_q + 32'd1;
        end
      end
      INIT: begin
        tx_nib = init_nib(step_q);
        case (step_q)
          4'd0:       tx_post = P_4100;
          4'd1:       tx_post = P_100;
          4'd2, 4'd3: tx_post = P_40;
          4'd11:      tx_post = P_1640;
          default:    tx_post = step_q[0] ? P_40 : P_1;
        endcase
        if (!act_q) begin
          tx_start = 1'b1;
          act_n    = 1'b1;
        end else if (tx_done) begin
          act_n = 1'b0;
          if (step_q == 4'd11) begin
            step_n = '0;
            st_n   = IDLE;
          end else begin
            step_n = step_q + 4'd1;
          end
        end
      end
      IDLE: begin
        if (req || pend_q) begin
          pend_n = 1'b0;
          row_n  = 1'b0;
          col_n  = '0;
          lo_n   = 1'b0;
          st_n   = SET_ADDR;
        end
      end
      SET_ADDR: begin
        tx_nib  = lo_q ? cmd[3:0] : cmd[7:4];
        tx_post = lo_q ? P_40 : P_1;
        if (!act_q) begin
          tx_start = 1'b1;
          act_n    = 1'b1;
        end else if (tx_done) begin
          act_n = 1'b0;
          lo_n  = !lo_q;
          if (lo_q) st_n = WRITE_CHAR;
        end
      end
      WRITE_CHAR: begin
        tx_rs   = 1'b1;
        // high nibble reads live so late writes still land
        tx_nib  = lo_q ? byte_q[3:0] : rd_char[7:4];
        tx_post = lo_q ? P_40 : P_1;
        if (!act_q) begin
          tx_start = 1'b1;
          act_n    = 1'b1;
          if (!lo_q) byte_n = rd_char;
        end else if (tx_done) begin
          act_n = 1'b0;
          lo_n  = !lo_q;
          if (lo_q) begin
            if (col_q == CW'(COLS - 1)) begin
              col_n = '0;
              if (ROWS == 1 || row_q) begin
                st_n = IDLE;
              end else begin
                row_n = 1'b1;
                st_n  = SET_ADDR;
              end
            end else begin
              col_n = col_q + CW'(1);
            end
          end
        end
      end
      default: st_n = POWER_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= POWER_WAIT;
      wcnt_q <= '0;
      step_q <= '0;
      lo_q   <= 1'b0;
      row_q  <= 1'b0;
      col_q  <= '0;
      byte_q <= '0;
      act_q  <= 1'b0;
      pend_q <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      st_q   <= st_n;
      wcnt_q <= wcnt_n;
      step_q <= step_n;
      lo_q   <= lo_n;
      row_q  <= row_n;
      col_q  <= col_n;
      byte_q <= byte_n;
      act_q  <= act_n;
      pend_q <= pend_n;
      busy_q <= (st_n != IDLE);
    end
  end

  lcd_nibble_tx #(
    .CLK_HZ (CLK_HZ)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (tx_start),
    .nib    (tx_nib),
    .rs     (tx_rs),
    .post   (tx_post),
    .done   (tx_done),
    .lcd_e  (lcd_e),
    .lcd_rs (lcd_rs),
    .lcd_d  (lcd_d)
  );

  assign host.busy = busy_q;
  assign sf_e      = 1'b1;
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// tb_lcd_text_ctrl: directed bench for the LCD text
// controller with a nibble-capturing LCD model.
module tb_lcd_text_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_text_ctrl_if #(.AW(6)) hif ();

  logic       sf_e, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;

  lcd_text_ctrl #(
    .CLK_HZ     (1_000_000),
    .ROWS       (2),
    .COLS       (16),
    .REFRESH_HZ (0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .host   (hif.slave),
    .sf_e   (sf_e),
    .lcd_e  (lcd_e),
    .lcd_rs (lcd_rs),
    .lcd_rw (lcd_rw),
    .lcd_d  (lcd_d)
  );

  logic        t_rst_n = 1'b0;
  logic        t_start, t_rs, t_done;
  logic [3:0]  t_nib, t_d;
  logic [31:0] t_post;
  logic        t_e, t_rs_o;

  lcd_nibble_tx #(
    .CLK_HZ (50_000_000)
  ) u_tx50 (
    .clk    (clk),
    .rst_n  (t_rst_n),
    .start  (t_start),
    .nib    (t_nib),
    .rs     (t_rs),
    .post   (t_post),
    .done   (t_done),
    .lcd_e  (t_e),
    .lcd_rs (t_rs_o),
    .lcd_d  (t_d)
  );

  localparam logic [3:0] INIT_EXP [12] = '{
    4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
    4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1
  };

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] mdl [32];

  logic       e_prev = 1'b0;
  logic [4:0] nq [$];
  longint     rise_t = -1;

  always @(negedge clk) begin
    if (lcd_e && !e_prev) begin
      nq.push_back({lcd_rs, lcd_d});
      if (rise_t < 0) rise_t = longint'($time);
    end
    e_prev = lcd_e;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(
    input logic [5:0] a,
    input logic [7:0] d
  );
    @(negedge clk);
    hif.wr_en   = 1'b1;
    hif.wr_addr = a;
    hif.wr_data = d;
    @(negedge clk);
    hif.wr_en   = 1'b0;
  endtask

  task automatic pulse();
    @(negedge clk);
    hif.refresh_req = 1'b1;
    @(negedge clk);
    hif.refresh_req = 1'b0;
  endtask

  task automatic wait_idle(
    input string tag,
    input int    lim
  );
    int n = 0;
    while (hif.busy !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(hif.busy), 0);
  endtask

  task automatic chk_init(
    input string  tag,
    input longint rel
  );
    longint dt;
    wait_idle({tag, "_idle"}, 30000);
    chk({tag, "_len"}, nq.size(), 12);
    for (int i = 0; i < 12 && i < nq.size(); i++)
      chk($sformatf("%s_n%0d", tag, i),
          32'(nq[i]), {27'd0, 1'b0, INIT_EXP[i]});
    dt = (rise_t - rel) / 10;
    chk({tag, "_first_rise"}, 32'(dt), 15002);
  endtask

  task automatic chk_paint(
    input string tag,
    input int    reps
  );
    logic [8:0] by [$];
    logic [4:0] ex [$];
    for (int r = 0; r < reps; r++) begin
      by.push_back({1'b0, 8'h80});
      for (int c = 0; c < 16; c++)
        by.push_back({1'b1, mdl[c]});
      by.push_back({1'b0, 8'hC0});
      for (int c = 0; c < 16; c++)
        by.push_back({1'b1, mdl[16 + c]});
    end
    for (int k = 0; k < by.size(); k++) begin
      ex.push_back({by[k][8], by[k][7:4]});
      ex.push_back({by[k][8], by[k][3:0]});
    end
    chk({tag, "_len"}, nq.size(), ex.size());
    for (int i = 0; i < ex.size() && i < nq.size(); i++)
      chk($sformatf("%s_n%0d", tag, i),
          32'(nq[i]), 32'(ex[i]));
  endtask

  initial begin
    longint rel;
    int n;
    hif.wr_en       = 1'b0;
    hif.wr_addr     = '0;
    hif.wr_data     = '0;
    hif.refresh_req = 1'b0;
    t_start = 1'b0;
    t_nib   = 4'h0;
    t_rs    = 1'b0;
    t_post  = '0;
    for (int i = 0; i < 32; i++) mdl[i] = 8'h20;

    repeat (3) @(negedge clk);
    chk("rst_e",    32'(lcd_e), 0);
    chk("rst_rs",   32'(lcd_rs), 0);
    chk("rst_rw",   32'(lcd_rw), 0);
    chk("rst_d",    32'(lcd_d), 0);
    chk("rst_sf_e", 32'(sf_e), 1);
    chk("rst_busy", 32'(hif.busy), 1);

    // 50 MHz strobe timing on the nibble transmitter
    t_rst_n = 1'b1;
    t_nib   = 4'hA;
    t_rs    = 1'b1;
    t_post  = 32'd2000;
    @(negedge clk);
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    chk("tx_d", 32'(t_d), 32'hA);
    chk("tx_rs", 32'(t_rs_o), 1);
    n = 0;
    while (!t_e && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tx_setup", n, 2);
    n = 0;
    while (t_e && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tx_high", n, 12);
    t_nib = 4'h5;
    n = 0;
    while (!t_e && n < 5000) begin
      @(negedge clk);
      n++;
      t_start = t_done;
    end
    t_start = 1'b0;
    chk("tx_gap", n, 2003);
    chk("tx_d2", 32'(t_d), 32'h5);

    // power-up init
    @(negedge clk);
    rst_n  = 1'b1;
    rel    = longint'($time);
    nq.delete();
    rise_t = -1;
    chk_init("init", rel);

    // HELLO repaint
    wr(6'd0, 8'h48);
    wr(6'd1, 8'h45);
    wr(6'd2, 8'h4C);
    wr(6'd3, 8'h4C);
    wr(6'd4, 8'h4F);
    mdl[0] = 8'h48;
    mdl[1] = 8'h45;
    mdl[2] = 8'h4C;
    mdl[3] = 8'h4C;
    mdl[4] = 8'h4F;
    nq.delete();
    pulse();
    repeat (2) @(negedge clk);
    chk("rp1_busy", 32'(hif.busy), 1);
    wait_idle("rp1_idle", 5000);
    chk_paint("rp1", 1);
    chk("rp1_rw", 32'(lcd_rw), 0);

    // late write lands; three requests merge to one
    nq.delete();
    pulse();
    repeat (100) @(negedge clk);
    wr(6'd31, 8'h5A);
    mdl[31] = 8'h5A;
    repeat (3) begin
      repeat (50) @(negedge clk);
      pulse();
    end
    repeat (6000) @(negedge clk);
    chk("mrg_idle", 32'(hif.busy), 0);
    chk_paint("mrg", 2);

    // out-of-range write ignored
    wr(6'd32, 8'h51);
    nq.delete();
    pulse();
    repeat (2) @(negedge clk);
    wait_idle("oor_idle", 5000);
    chk_paint("oor", 1);

    // reset during a strobe
    nq.delete();
    pulse();
    n = 0;
    while (!(lcd_e === 1'b1 && nq.size() >= 20) &&
           n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_e_hi", 32'(lcd_e), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_e", 32'(lcd_e), 0);
    chk("mid_rst_busy", 32'(hif.busy), 1);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    rel    = longint'($time);
    nq.delete();
    rise_t = -1;
    for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
    chk_init("reinit", rel);
    nq.delete();
    pulse();
    repeat (2) @(negedge clk);
    wait_idle("sp_idle", 5000);
    chk_paint("sp", 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_text_ctrl.md
LCD_TEXT_CTRL -- requirements
Module: lcd_text_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency; all LCD delays derive from it, rounded up to whole cycles.
REQ-002 Parameter ROWS, default 2, display lines (1 or 2).
REQ-003 Parameter COLS, default 16, characters per line (8..40).
REQ-004 Parameter REFRESH_HZ, default 25, auto-refresh rate; 0 disables auto-refresh.
REQ-005 clk  in  1  system clock (50 MHz on board).
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 wr_en  in  1  character buffer write strobe, one byte per cycle.
REQ-008 wr_addr  in  clog2(ROWS*COLS)  buffer index, row*COLS+col.
REQ-009 wr_data  in  8  ASCII character.
REQ-010 refresh_req  in  1  single-cycle request to repaint the display.
REQ-011 busy  out  1  high during init or repaint.
REQ-012 sf_e  out  1  LCD access select; constant 1 after reset.
REQ-013 lcd_e, lcd_rs, lcd_rw  out  1 each  LCD enable, register select, read/write (rw always 0).
REQ-014 lcd_d  out  4  LCD data nibble, high nibble first.

Function
REQ-015 States: POWER_WAIT, INIT, IDLE, SET_ADDR, WRITE_CHAR; exit from reset enters POWER_WAIT.
REQ-016 POWER_WAIT: hold 15 ms, then INIT.
REQ-017 INIT: nibble 0x3 + wait 4.1 ms, 0x3 + wait 100 us, 0x3 + wait 40 us, 0x2 + wait 40 us; then bytes 0x28, 0x06, 0x0C, 0x01 (rs=0), wait 1.64 ms after 0x01, 40 us after the others; then IDLE.
REQ-018 Nibble transfer: lcd_rs/lcd_d stable >=40 ns before lcd_e rises; lcd_e high >=230 ns; data held >=10 ns after fall; >=1 us between nibbles of one byte; >=40 us after each byte.
REQ-019 IDLE -> SET_ADDR on refresh_req or auto-refresh tick (every CLK_HZ/REFRESH_HZ cycles, free-running).
REQ-020 SET_ADDR sends command 0x80 | row base (row 0 = 0x00, row 1 = 0x40), rs=0; WRITE_CHAR then sends COLS buffer bytes, rs=1; after the last row, IDLE.
REQ-021 Each character byte is read from the buffer when its high nibble starts; both nibbles use the same latched byte.
REQ-022 Buffer writes accepted in every state, including mid-repaint; a write to a not-yet-sent position appears in the current repaint.
REQ-023 wr_addr >= ROWS*COLS: write ignored.
REQ-024 refresh_req or tick while busy: one pending flag set; one repaint starts on return to IDLE; further requests merge.
REQ-025 busy = 1 in every state except IDLE; falls the cycle IDLE is entered.
REQ-026 lcd_e, lcd_rs, lcd_rw, lcd_d and busy are registered outputs.

Reset
REQ-027 On rst_n low, immediately: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0, sf_e=1, busy=1, pending=0, all counters 0, state POWER_WAIT.
REQ-028 Reset mid-transfer aborts the transfer; the full init sequence reruns after release.
REQ-029 Buffer contents after reset are ASCII space (0x20).

Structure
REQ-030 Shared package lcd_pkg holds the command constants (0x28, 0x06, 0x0C, 0x01, 0x80, 0x40 row offset), the state enumeration, and the microsecond-to-cycles function.
REQ-031 One sub-module, lcd_nibble_tx: takes a nibble, rs and post-delay, drives lcd_e/lcd_d with REQ-018 timing, and pulses done; the top FSM sequences it.

Verification
REQ-032 CLK_HZ=1_000_000, release rst_n -> first lcd_e rise at cycle >=15000 with lcd_d=0x3, rs=0; eleven INIT nibbles follow in REQ-017 order, then busy falls.
REQ-033 After init, write "HELLO" to addresses 0..4, pulse refresh_req -> bytes 0x80, 0x48 0x45 0x4C 0x4C 0x4F, then eleven 0x20, then 0xC0 and sixteen 0x20; the LCD model decodes all of it.
REQ-034 Pulse refresh_req three times during a repaint -> exactly one extra repaint follows.
REQ-035 wr_addr=32 with ROWS=2, COLS=16 -> buffer unchanged; the next repaint matches the prior content.
REQ-036 Timing checker on every lcd_e pulse at CLK_HZ=50_000_000 -> setup >=2 cycles, high width >=12 cycles, and inter-byte gap >=2000 cycles.
REQ-037 Assert rst_n low while lcd_e is high mid-repaint -> lcd_e=0 in the same cycle; after release, the full init sequence reruns and buffer reads back spaces.
